// File: rtl/pong_pkg.sv
// Shared paddle constants and the per-channel state encoding.
// PADDLE_FULL_RANGE_EN selects the shorter minimum delay in the channels.
package pong_pkg;

  localparam int VOFS_DEF    = 21;
  localparam int VMIN_DEF    = 38;
  localparam int VMIN_FR_DEF = 22;
  localparam int PAD_H_DEF   = 15;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_DRAW  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/paddle_chan.sv
// One paddle channel: 555-style line countdown followed by a PAD_H-line draw window.
// PADDLE_FULL_RANGE_EN: minimum delay is VMIN_FR instead of VMIN.
module paddle_chan
  import pong_pkg::*;
#(
  parameter int POS_W   = 8,
  parameter int CNT_W   = 9,
  parameter int ROW_W   = 4,
  parameter int VOFS    = VOFS_DEF,
  parameter int VMIN    = VMIN_DEF,
  parameter int VMIN_FR = VMIN_FR_DEF,
  parameter int PAD_H   = PAD_H_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ln_i,
  input  logic             v256_n_i,
  input  logic [POS_W-1:0] vpos_i,
  output logic [ROW_W-1:0] row_o,
  output logic             vpad_n_o,
  output chan_state_e      state_o
);

`ifdef PADDLE_FULL_RANGE_EN
  localparam int MIN_DELAY = VMIN_FR;
`else
  localparam int MIN_DELAY = VMIN;
`endif

  localparam logic [CNT_W-1:0] VOFS_C  = CNT_W'(VOFS);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ROW_W-1:0] PAD_H_C = ROW_W'(PAD_H);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             vpad_n_q, vpad_n_d;
  logic [CNT_W-1:0] load_sum, load_val;

  // CNT_W is sized so the offset sum never wraps.
  assign load_sum = CNT_W'(vpos_i) + VOFS_C;
  assign load_val = (load_sum < MIN_C) ? MIN_C : load_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      row_q    <= PAD_H_C;
      vpad_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      row_q    <= row_d;
      vpad_n_q <= vpad_n_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    row_d    = row_q;
    vpad_n_d = vpad_n_q;
    if (ln_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) trig_d = 1'b0;
      end else if (!v256_n_i) begin
        cnt_d  = load_val;
        trig_d = 1'b1;
      end
      // Row follows the trigger as it was before this line.
      if (trig_q) row_d = '0;
      else if (row_q != PAD_H_C) row_d = row_q + ROW_ONE;
      vpad_n_d = trig_d | (row_d == PAD_H_C);
    end
  end

  always_comb begin
    if (trig_q)                state_o = CH_DELAY;
    else if (row_q != PAD_H_C) state_o = CH_DRAW;
    else                       state_o = CH_IDLE;
    row_o    = row_q;
    vpad_n_o = vpad_n_q;
  end

endmodule

// File: rtl/paddle_array.sv
// N-channel paddle vertical generator with a shared line-strobe detector.
// PADDLE_FULL_RANGE_EN (see paddle_chan) lowers the minimum delay for full-screen reach.
module paddle_array
  import pong_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int POS_W   = 8,
  parameter int CNT_W   = 9,
  parameter int VOFS    = VOFS_DEF,
  parameter int VMIN    = VMIN_DEF,
  parameter int VMIN_FR = VMIN_FR_DEF,
  parameter int PAD_H   = PAD_H_DEF,
  parameter int ROW_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsync_n,
  input  logic                 v256_n,
  input  logic [NCH*POS_W-1:0] paddle_vpos,
  output logic [NCH*ROW_W-1:0] row,
  output logic [NCH-1:0]       vpad_n,
  output logic [NCH*2-1:0]     dbg_state
);

  logic hs_q;
  logic ln;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hs_q <= 1'b1;
    else       hs_q <= hsync_n;
  end

  // One-cycle strobe on the falling edge of hsync_n.
  assign ln = hs_q & ~hsync_n;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    chan_state_e st;

    paddle_chan #(
      .POS_W  (POS_W),
      .CNT_W  (CNT_W),
      .ROW_W  (ROW_W),
      .VOFS   (VOFS),
      .VMIN   (VMIN),
      .VMIN_FR(VMIN_FR),
      .PAD_H  (PAD_H)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .ln_i    (ln),
      .v256_n_i(v256_n),
      .vpos_i  (paddle_vpos[g*POS_W +: POS_W]),
      .row_o   (row[g*ROW_W +: ROW_W]),
      .vpad_n_o(vpad_n[g]),
      .state_o (st)
    );

    assign dbg_state[g*2 +: 2] = st;
  end

endmodule
